// File: rtl/w_ptr_handler_if.sv
// Write-side bus of the async FIFO pointer handler: producer handshake,
// synchronized read pointer in, memory strobe and status flags out.
interface w_ptr_handler_if #(
  parameter int ADDR_W = 3
);
  logic              i_wen;
  logic              i_clr_ovf;
  logic [ADDR_W:0]   g_r_ptr_sync;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [ADDR_W:0]   g_w_ptr;
  logic              full_flag;
  logic              almost_full;
  logic [ADDR_W:0]   o_wlevel;
  logic              o_overflow;

  modport master (
    output i_wen, i_clr_ovf, g_r_ptr_sync,
    input  o_mem_we, o_waddr, g_w_ptr, full_flag, almost_full, o_wlevel, o_overflow
  );

  modport slave (
    input  i_wen, i_clr_ovf, g_r_ptr_sync,
    output o_mem_we, o_waddr, g_w_ptr, full_flag, almost_full, o_wlevel, o_overflow
  );
endinterface

// File: rtl/w_ptr_handler.sv
// Write-domain pointer logic of an async FIFO: binary/gray write pointer,
// full/almost-full/level from the synchronized read pointer, sticky overflow.
module w_ptr_handler #(
  parameter int ADDR_W       = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic            i_wclk,
  input  logic            i_rst_n,
  w_ptr_handler_if.slave  bus
);
  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [ADDR_W:0] w_bin_q, w_bin_d;
  logic [ADDR_W:0] g_w_ptr_q, g_w_ptr_d;
  logic [ADDR_W:0] wlevel_q, wlevel_d;
  logic [ADDR_W:0] r_bin;
  logic [ADDR_W:0] full_cmp;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;
  logic            wr_accept;

  always_comb begin
    wr_accept = bus.i_wen & ~full_q & i_rst_n;
    w_bin_d   = w_bin_q + PW'(wr_accept);
    g_w_ptr_d = w_bin_d ^ (w_bin_d >> 1);

    // Bit i of the binary read pointer is the XOR of gray bits MSB..i.
    r_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      r_bin[i] = ^(bus.g_r_ptr_sync >> i);
    end

    // Full when the write pointer has lapped the read pointer exactly once.
    full_cmp = {~bus.g_r_ptr_sync[ADDR_W:ADDR_W-1], bus.g_r_ptr_sync[ADDR_W-2:0]};
    full_d   = (g_w_ptr_d == full_cmp);
    wlevel_d = w_bin_d - r_bin;
    afull_d  = (wlevel_d >= AFULL_LVL);

    // A new overflow event takes priority over a concurrent clear.
    ovf_d = ovf_q;
    if (bus.i_clr_ovf) ovf_d = 1'b0;
    if (bus.i_wen && full_q) ovf_d = 1'b1;
  end

  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_bin_q   <= '0;
      g_w_ptr_q <= '0;
      wlevel_q  <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      w_bin_q   <= w_bin_d;
      g_w_ptr_q <= g_w_ptr_d;
      wlevel_q  <= wlevel_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.o_mem_we    = wr_accept;
  assign bus.o_waddr     = w_bin_q[ADDR_W-1:0];
  assign bus.g_w_ptr     = g_w_ptr_q;
  assign bus.full_flag   = full_q;
  assign bus.almost_full = afull_q;
  assign bus.o_wlevel    = wlevel_q;
  assign bus.o_overflow  = ovf_q;
endmodule
